// File: rtl/ex_operand_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage (package ex_pkg).
package ex_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned RegAw = 5;

  // ALU selection codes driven to the execute stage.
  typedef enum logic [3:0] {
    SelAnd = 4'b0000,
    SelOr  = 4'b0001,
    SelAdd = 4'b0010,
    SelSub = 4'b0110,
    SelSlt = 4'b0111
  } alu_sel_t;

  // ALUOp encodings from the main decoder.
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpRtype = 2'b10;
  localparam logic [1:0] AluOpRsvd  = 2'b11;

  // R-type funct encodings.
  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  // Registered ID/EX payload. rs/rt/alu_src are kept so a held operand can be refreshed.
  typedef struct packed {
    alu_sel_t           sel;
    logic [DataW-1:0]   input1;
    logic [DataW-1:0]   input2;
    logic [DataW-1:0]   store_data;
    logic [RegAw-1:0]   dest;
    logic               reg_write;
    logic [RegAw-1:0]   rs;
    logic [RegAw-1:0]   rt;
    logic               alu_src;
  } ex_payload_t;

  localparam ex_payload_t PayloadRst = '{sel: SelAdd, default: '0};

  // A forward source matches only if it writes a non-zero register equal to the index.
  function automatic logic fwd_hit(input logic we, input logic [RegAw-1:0] rd,
                                   input logic [RegAw-1:0] idx);
    return we && (rd != '0) && (rd == idx);
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID -> EX request channel: valid/ready handshake plus decoded instruction fields.
interface ex_operand_stage_if
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned REG_AW = RegAw
);
  logic              id_valid;
  logic              id_ready;
  logic [1:0]        id_alu_op;
  logic [5:0]        id_funct;
  logic              id_alu_src;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_dest;
  logic              id_reg_write;

  // ID stage side.
  modport master (
    output id_valid, id_alu_op, id_funct, id_alu_src, id_rs, id_rt,
           id_rs_data, id_rt_data, id_imm, id_dest, id_reg_write,
    input  id_ready
  );

  // Operand stage side.
  modport slave (
    input  id_valid, id_alu_op, id_funct, id_alu_src, id_rs, id_rt,
           id_rs_data, id_rt_data, id_imm, id_dest, id_reg_write,
    output id_ready
  );
endinterface

// File: rtl/ex_operand_stage_alu_ctrl_decode.sv
// Combinational ALUOp/funct -> ALU selection decode with illegal-encoding flag.
module alu_ctrl_decode
  import ex_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_sel_t   sel,
  output logic       illegal
);

  // Illegal encodings fall back to ADD so the datapath always sees a defined code.
  always_comb begin
    sel     = SelAdd;
    illegal = 1'b0;
    unique case (alu_op)
      AluOpAdd: sel = SelAdd;
      AluOpSub: sel = SelSub;
      AluOpRtype: begin
        case (funct)
          FunctAdd: sel = SelAdd;
          FunctSub: sel = SelSub;
          FunctAnd: sel = SelAnd;
          FunctOr:  sel = SelOr;
          FunctSlt: sel = SelSlt;
          default:  illegal = 1'b1;
        endcase
      end
      AluOpRsvd: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: ALU control decode, EX/MEM and MEM/WB forwarding, operand-2 select,
// and a valid/ready pipeline register with stall-hold operand refresh and flush-to-bubble.
// Optional feature macro ILLEGAL_OP_TRAP_EN adds the registered ex_illegal output and
// suppresses ex_reg_write for illegal decodes.
module ex_operand_stage
  import ex_pkg::*;
#(
  // Data/index widths must match the ex_pkg payload widths.
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned REG_AW = RegAw,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  ex_operand_stage_if.slave   id_bus,
  input  logic                exmem_reg_write,
  input  logic [REG_AW-1:0]   exmem_rd,
  input  logic [DATA_W-1:0]   exmem_result,
  input  logic                memwb_reg_write,
  input  logic [REG_AW-1:0]   memwb_rd,
  input  logic [DATA_W-1:0]   memwb_result,
  input  logic                flush,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [3:0]          ex_sel,
  output logic [DATA_W-1:0]   ex_input1,
  output logic [DATA_W-1:0]   ex_input2,
  output logic [DATA_W-1:0]   ex_store_data,
  output logic [REG_AW-1:0]   ex_dest,
  output logic                ex_reg_write,
  output logic [CNT_W-1:0]    bubble_count
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic                ex_illegal
`endif
);

  alu_sel_t          dec_sel;
  logic              dec_illegal;
  logic              accept;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  ex_payload_t       in_pay;
  ex_payload_t       pay_d, pay_q;
  logic              valid_d, valid_q;
  logic [CNT_W-1:0]  bubble_d, bubble_q;
`ifdef ILLEGAL_OP_TRAP_EN
  logic              illegal_d, illegal_q;
`endif

  alu_ctrl_decode u_alu_ctrl_decode (
    .alu_op  (id_bus.id_alu_op),
    .funct   (id_bus.id_funct),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  // Handshake: the register can take a new instruction when empty or being drained.
  always_comb begin
    id_bus.id_ready = !valid_q || ex_ready;
    accept          = id_bus.id_valid && id_bus.id_ready;
  end

  // Operand forwarding: EX/MEM beats MEM/WB beats register file; r0 always reads zero.
  always_comb begin
    rs_fwd = id_bus.id_rs_data;
    if (fwd_hit(exmem_reg_write, exmem_rd, id_bus.id_rs)) begin
      rs_fwd = exmem_result;
    end else if (fwd_hit(memwb_reg_write, memwb_rd, id_bus.id_rs)) begin
      rs_fwd = memwb_result;
    end else if (id_bus.id_rs == '0) begin
      rs_fwd = '0;
    end

    rt_fwd = id_bus.id_rt_data;
    if (fwd_hit(exmem_reg_write, exmem_rd, id_bus.id_rt)) begin
      rt_fwd = exmem_result;
    end else if (fwd_hit(memwb_reg_write, memwb_rd, id_bus.id_rt)) begin
      rt_fwd = memwb_result;
    end else if (id_bus.id_rt == '0) begin
      rt_fwd = '0;
    end
  end

  // Assemble the incoming payload from decode, forwarded operands and passthrough fields.
  always_comb begin
    in_pay            = PayloadRst;
    in_pay.sel        = dec_sel;
    in_pay.input1     = rs_fwd;
    in_pay.input2     = id_bus.id_alu_src ? id_bus.id_imm : rt_fwd;
    in_pay.store_data = rt_fwd;
    in_pay.dest       = id_bus.id_dest;
`ifdef ILLEGAL_OP_TRAP_EN
    in_pay.reg_write  = id_bus.id_reg_write && !dec_illegal;
`else
    in_pay.reg_write  = id_bus.id_reg_write;
`endif
    in_pay.rs         = id_bus.id_rs;
    in_pay.rt         = id_bus.id_rt;
    in_pay.alu_src    = id_bus.id_alu_src;
  end

  // Next state: flush > accept > drain > hold (with MEM/WB refresh of held operands).
  always_comb begin
    pay_d   = pay_q;
    valid_d = valid_q;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_d = illegal_q;
`endif
    if (flush) begin
      valid_d         = 1'b0;
      pay_d.reg_write = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_d       = 1'b0;
`endif
    end else if (accept) begin
      valid_d = 1'b1;
      pay_d   = in_pay;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_d = dec_illegal;
`endif
    end else if (!valid_q || ex_ready) begin
      valid_d = 1'b0;
    end else begin
      // Stalled: a producer may retire through MEM/WB while we wait, so pick up its result.
      if (fwd_hit(memwb_reg_write, memwb_rd, pay_q.rs)) begin
        pay_d.input1 = memwb_result;
      end
      if (fwd_hit(memwb_reg_write, memwb_rd, pay_q.rt)) begin
        pay_d.store_data = memwb_result;
        if (!pay_q.alu_src) begin
          pay_d.input2 = memwb_result;
        end
      end
    end
  end

  // Bubble counter: counts cycles with no valid output, saturating at all-ones.
  always_comb begin
    bubble_d = bubble_q;
    if (!valid_q && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Pipeline and counter state; synchronous reset takes priority over hold and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      pay_q    <= PayloadRst;
      bubble_q <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      valid_q  <= valid_d;
      pay_q    <= pay_d;
      bubble_q <= bubble_d;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Registered outputs.
  always_comb begin
    ex_valid      = valid_q;
    ex_sel        = pay_q.sel;
    ex_input1     = pay_q.input1;
    ex_input2     = pay_q.input2;
    ex_store_data = pay_q.store_data;
    ex_dest       = pay_q.dest;
    ex_reg_write  = pay_q.reg_write;
    bubble_count  = bubble_q;
`ifdef ILLEGAL_OP_TRAP_EN
    ex_illegal    = illegal_q;
`endif
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: vector table plus hold/flush/reset/saturation
// sequences. Honours ILLEGAL_OP_TRAP_EN for the illegal-decode expectations.
module tb_ex_operand_stage;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic IllRw = 1'b0;
`else
  localparam logic IllRw = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        flush, ex_ready;
  logic        ex_valid, ex_reg_write;
  logic [3:0]  ex_sel;
  logic [31:0] ex_input1, ex_input2, ex_store_data;
  logic [4:0]  ex_dest;
  logic [3:0]  bubble_count;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        ex_illegal;
`endif

  int checks = 0;
  int failures = 0;

  ex_operand_stage_if id_bus ();

  ex_operand_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_bus          (id_bus),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .flush           (flush),
    .ex_ready        (ex_ready),
    .ex_valid        (ex_valid),
    .ex_sel          (ex_sel),
    .ex_input1       (ex_input1),
    .ex_input2       (ex_input2),
    .ex_store_data   (ex_store_data),
    .ex_dest         (ex_dest),
    .ex_reg_write    (ex_reg_write),
    .bubble_count    (bubble_count)
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    .ex_illegal      (ex_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        src;
    logic [4:0]  rs, rt;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  dest;
    logic        rw;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic [3:0]  e_sel;
    logic [31:0] e_in1, e_in2, e_st;
    logic        e_rw;
    logic        e_ill;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic src,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rs_d,
                       input logic [31:0] rt_d, input logic [31:0] imm, input logic [4:0] dest,
                       input logic rw);
    id_bus.id_alu_op    = op;
    id_bus.id_funct     = funct;
    id_bus.id_alu_src   = src;
    id_bus.id_rs        = rs;
    id_bus.id_rt        = rt;
    id_bus.id_rs_data   = rs_d;
    id_bus.id_rt_data   = rt_d;
    id_bus.id_imm       = imm;
    id_bus.id_dest      = dest;
    id_bus.id_reg_write = rw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 6'b100010, 1'b0, 5'd1, 5'd2, 32'd9, 32'd4, 32'd0, 5'd3, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0110, 32'd9, 32'd4, 32'd4, 1'b1, 1'b0};
    vecs[1]  = '{2'b00, 6'b000000, 1'b1, 5'd3, 5'd4, 32'h10, 32'h55, 32'hFFFF_FFF0, 5'd8, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0010, 32'h10, 32'hFFFF_FFF0, 32'h55,
                 1'b1, 1'b0};
    vecs[2]  = '{2'b01, 6'b000000, 1'b0, 5'd7, 5'd8, 32'd100, 32'd30, 32'd0, 5'd9, 1'b0,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0110, 32'd100, 32'd30, 32'd30, 1'b0,
                 1'b0};
    vecs[3]  = '{2'b10, 6'b100100, 1'b0, 5'd1, 5'd2, 32'hF0F0, 32'hFF00, 32'd0, 5'd10, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0000, 32'hF0F0, 32'hFF00, 32'hFF00,
                 1'b1, 1'b0};
    vecs[4]  = '{2'b10, 6'b100101, 1'b0, 5'd1, 5'd2, 32'hF0F0, 32'hFF00, 32'd0, 5'd10, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0001, 32'hF0F0, 32'hFF00, 32'hFF00,
                 1'b1, 1'b0};
    vecs[5]  = '{2'b10, 6'b101010, 1'b0, 5'd1, 5'd2, 32'hF0F0, 32'hFF00, 32'd0, 5'd11, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0111, 32'hF0F0, 32'hFF00, 32'hFF00,
                 1'b1, 1'b0};
    vecs[6]  = '{2'b10, 6'b100000, 1'b0, 5'd1, 5'd2, 32'd5, 32'd6, 32'd0, 5'd12, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0010, 32'd5, 32'd6, 32'd6, 1'b1, 1'b0};
    // EX/MEM and MEM/WB both match rs: EX/MEM wins.
    vecs[7]  = '{2'b00, 6'b000000, 1'b1, 5'd5, 5'd6, 32'd11, 32'd22, 32'h40, 5'd12, 1'b1,
                 1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 4'b0010, 32'hAA, 32'h40, 32'd22, 1'b1,
                 1'b0};
    // rs = r0 with matching-index sources: still zero.
    vecs[8]  = '{2'b00, 6'b000000, 1'b1, 5'd0, 5'd6, 32'd11, 32'd22, 32'h40, 5'd12, 1'b1,
                 1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 4'b0010, 32'h0, 32'h40, 32'd22, 1'b1,
                 1'b0};
    // EX/MEM not writing: MEM/WB supplies rs and rt.
    vecs[9]  = '{2'b00, 6'b000000, 1'b0, 5'd5, 5'd5, 32'd11, 32'd22, 32'h40, 5'd13, 1'b1,
                 1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 4'b0010, 32'hBB, 32'hBB, 32'hBB, 1'b1,
                 1'b0};
    // rt = r0 with EX/MEM writing r0: no forward, reads zero.
    vecs[10] = '{2'b00, 6'b000000, 1'b0, 5'd3, 5'd0, 32'd7, 32'h99, 32'h0, 5'd14, 1'b1,
                 1'b1, 5'd0, 32'h12, 1'b0, 5'd0, 32'h0, 4'b0010, 32'd7, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[11] = '{2'b10, 6'b000111, 1'b0, 5'd1, 5'd2, 32'd9, 32'd4, 32'd0, 5'd15, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0010, 32'd9, 32'd4, 32'd4, IllRw, 1'b1};
    vecs[12] = '{2'b11, 6'b100000, 1'b0, 5'd1, 5'd2, 32'd9, 32'd4, 32'd0, 5'd16, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0010, 32'd9, 32'd4, 32'd4, IllRw, 1'b1};

    // Reset for two cycles.
    reset = 1'b1;
    flush = 1'b0;
    ex_ready = 1'b1;
    id_bus.id_valid = 1'b0;
    drive(2'b00, 6'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    tick();
    tick();
    check("rst.valid", ex_valid, 0);
    check("rst.sel", ex_sel, 4'b0010);
    check("rst.in1", ex_input1, 0);
    check("rst.rw", ex_reg_write, 0);
    check("rst.bubble", bubble_count, 0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle.bubble", bubble_count, 3);

    // Vector table, back-to-back with ex_ready held high.
    id_bus.id_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].funct, vecs[i].src, vecs[i].rs, vecs[i].rt, vecs[i].rs_d,
            vecs[i].rt_d, vecs[i].imm, vecs[i].dest, vecs[i].rw);
      exmem_reg_write = vecs[i].xw; exmem_rd = vecs[i].xrd; exmem_result = vecs[i].xres;
      memwb_reg_write = vecs[i].ww; memwb_rd = vecs[i].wrd; memwb_result = vecs[i].wres;
      tick();
      check($sformatf("v%0d.valid", i), ex_valid, 1);
      check($sformatf("v%0d.sel", i), ex_sel, vecs[i].e_sel);
      check($sformatf("v%0d.in1", i), ex_input1, vecs[i].e_in1);
      check($sformatf("v%0d.in2", i), ex_input2, vecs[i].e_in2);
      check($sformatf("v%0d.st", i), ex_store_data, vecs[i].e_st);
      check($sformatf("v%0d.dest", i), ex_dest, vecs[i].dest);
      check($sformatf("v%0d.rw", i), ex_reg_write, vecs[i].e_rw);
`ifdef ILLEGAL_OP_TRAP_EN
      check($sformatf("v%0d.ill", i), ex_illegal, vecs[i].e_ill);
`endif
    end
    exmem_reg_write = 1'b0;
    memwb_reg_write = 1'b0;

    // Hold with MEM/WB refresh of the stored rt.
    drive(2'b10, 6'b100000, 1'b0, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0, 5'd7, 1'b1);
    tick();
    check("hold.load.in2", ex_input2, 4);
    ex_ready = 1'b0;
    drive(2'b01, 6'd0, 1'b1, 5'd9, 5'd9, 32'h999, 32'h999, 32'h999, 5'd9, 1'b0);
    memwb_reg_write = 1'b1; memwb_rd = 5'd2; memwb_result = 32'h77;
    #1;
    check("hold.id_ready", id_bus.id_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("hold%0d.valid", c), ex_valid, 1);
      check($sformatf("hold%0d.in1", c), ex_input1, 3);
      check($sformatf("hold%0d.in2", c), ex_input2, 32'h77);
      check($sformatf("hold%0d.st", c), ex_store_data, 32'h77);
      check($sformatf("hold%0d.sel", c), ex_sel, 4'b0010);
      check($sformatf("hold%0d.dest", c), ex_dest, 7);
      check($sformatf("hold%0d.rw", c), ex_reg_write, 1);
      check($sformatf("hold%0d.id_ready", c), id_bus.id_ready, 0);
      // Non-matching MEM/WB writer must not disturb the held operands.
      memwb_rd = 5'd3; memwb_result = 32'h55;
    end
    memwb_reg_write = 1'b0;

    // Reset while holding clears the stage.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rsthold.valid", ex_valid, 0);
    check("rsthold.in1", ex_input1, 0);
    check("rsthold.bubble", bubble_count, 0);

    // Flush with a same-cycle incoming instruction.
    ex_ready = 1'b1;
    id_bus.id_valid = 1'b1;
    drive(2'b00, 6'd0, 1'b0, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 5'd4, 1'b1);
    tick();
    check("fl.pre.valid", ex_valid, 1);
    check("fl.pre.rw", ex_reg_write, 1);
    flush = 1'b1;
    drive(2'b01, 6'd0, 1'b0, 5'd3, 5'd4, 32'd5, 32'd6, 32'd0, 5'd6, 1'b1);
    #1;
    check("fl.id_ready", id_bus.id_ready, 1);
    tick();
    flush = 1'b0;
    id_bus.id_valid = 1'b0;
    check("fl.valid", ex_valid, 0);
    check("fl.rw", ex_reg_write, 0);
    tick();
    check("fl.dropped", ex_valid, 0);

    // Flush during a hold.
    id_bus.id_valid = 1'b1;
    tick();
    check("flh.pre.valid", ex_valid, 1);
    ex_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    id_bus.id_valid = 1'b0;
    ex_ready = 1'b1;
    check("flh.valid", ex_valid, 0);
    check("flh.rw", ex_reg_write, 0);

    // Bubble counter saturates at all-ones and does not wrap.
    repeat (20) tick();
    check("sat.bubble", bubble_count, 4'hF);
    tick();
    check("sat.hold", bubble_count, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
